icache: RTL and testbench

Direct-mapped instruction cache between the pipelined datapath's fetch stage and the memory controller's instruction port. It returns hits combinationally in the request cycle. On a miss it runs a single-word fill from the memory controller and answers the datapath one cycle after the fill completes. It also provides a whole-cache invalidate and saturating hit/miss counters for performance reporting.

---
 rtl/icache_if.sv | 23 ++
 rtl/icache.sv | 107 ++++++++++
 tb/tb_icache.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_if;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // Cache side: serves the datapath, requests from memory.
  modport slave (
    input  dp_imemREN, dp_imemaddr, iwait, iload,
    output dp_ihit, dp_imemload, iREN, iaddr
  );

  // Environment side: datapath requester plus memory responder.
  modport master (
    output dp_imemREN, dp_imemaddr, iwait, iload,
    input  dp_ihit, dp_imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hits, single-word fill on
// miss, whole-cache invalidate and saturating hit/miss counters.
module icache #(
  parameter int unsigned SETS = 16,
  parameter int unsigned CNTW = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  icache_if.slave         bus,
  input  logic            inv,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);
  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDXW;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state, state_n;
  logic [SETS-1:0] valid;
  logic [TAGW-1:0] tags [SETS];
  logic [31:0]     data [SETS];
  logic [29:0]     miss_word;

  logic [IDXW-1:0] req_idx, fill_idx;
  logic [TAGW-1:0] req_tag, fill_tag;
  logic            hit, miss, fill;
  logic            unused_offset;

  assign req_idx       = bus.dp_imemaddr[IDXW+1:2];
  assign req_tag       = bus.dp_imemaddr[31:IDXW+2];
  assign fill_idx      = miss_word[IDXW-1:0];
  assign fill_tag      = miss_word[29:IDXW];
  assign unused_offset = ^bus.dp_imemaddr[1:0];

  // State register; reset abandons any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, hit/miss detection and bus outputs.
  always_comb begin
    state_n         = state;
    hit             = 1'b0;
    miss            = 1'b0;
    fill            = 1'b0;
    bus.dp_ihit     = 1'b0;
    bus.dp_imemload = '0;
    bus.iREN        = 1'b0;
    bus.iaddr       = '0;
    case (state)
      IDLE: begin
        hit         = bus.dp_imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
        miss        = bus.dp_imemREN && !hit;
        bus.dp_ihit = hit;
        if (hit)  bus.dp_imemload = data[req_idx];
        if (miss) state_n = FETCH;
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_word, 2'b00};
        if (!bus.iwait) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Miss address capture; held for the whole fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     miss_word <= '0;
    else if (miss) miss_word <= bus.dp_imemaddr[31:2];
  end

  // Frame storage; invalidate is applied after the fill so it wins on a shared edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      if (fill) begin
        valid[fill_idx] <= 1'b1;
        tags[fill_idx]  <= fill_tag;
        data[fill_idx]  <= bus.iload;
      end
      if (inv) valid <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != CNT_MAX)   hit_count  <= hit_count + CNTW'(1);
      if (miss && miss_count != CNT_MAX) miss_count <= miss_count + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache with a transaction-level cache model
// and a scoreboard monitor that checks whenever the DUT presents data.
module tb_icache;
  localparam int unsigned SETS = 16;
  localparam int unsigned CNTW = 8;
  localparam int unsigned IDXW = 4;
  localparam int          CMAX = 255;

  logic            CLK;
  logic            nRST;
  logic            inv;
  logic [CNTW-1:0] hit_count, miss_count;

  icache_if bus();

  icache #(.SETS(SETS), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .inv(inv),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: a fixed scramble of the word address (word 0 -> 0x3C010001).
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'(({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h3C010001);
  endfunction

  assign bus.iload = mem(bus.iaddr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference model: frames hold the full word address they cache.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  bit          m_fetching;
  logic [31:0] m_faddr;
  int          m_hits, m_miss;

  logic [31:0] q_hit[$];
  logic [31:0] q_fetch[$];
  logic        exp_hit, exp_fetch;
  logic [31:0] exp_hc, exp_mc;
  bit          mon_en;

  function automatic logic [31:0] sat(input int n);
    return (n > CMAX) ? 32'(CMAX) : 32'(n);
  endfunction

  function automatic int fidx(input logic [31:0] a);
    return int'(a[IDXW+1:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(SETS); i++) m_valid[i] = 1'b0;
    m_fetching = 1'b0;
    m_hits = 0;
    m_miss = 0;
    exp_hit = 1'b0;
    exp_fetch = 1'b0;
    exp_hc = '0;
    exp_mc = '0;
    q_hit.delete();
    q_fetch.delete();
  endtask

  // One clock cycle of stimulus; the model predicts this cycle's responses.
  task automatic step(input logic ren, input logic [31:0] a, input logic iv, input logic w);
    @(posedge CLK);
    #1;
    bus.dp_imemREN  = ren;
    bus.dp_imemaddr = a;
    bus.iwait       = w;
    inv             = iv;
    exp_hc    = sat(m_hits);
    exp_mc    = sat(m_miss);
    exp_hit   = 1'b0;
    exp_fetch = 1'b0;
    if (m_fetching) begin
      exp_fetch = 1'b1;
      q_fetch.push_back({m_faddr[31:2], 2'b00});
      if (!w) begin
        m_valid[fidx(m_faddr)] = 1'b1;
        m_word[fidx(m_faddr)]  = m_faddr[31:2];
        m_fetching = 1'b0;
      end
    end else if (ren) begin
      if (m_valid[fidx(a)] && m_word[fidx(a)] == a[31:2]) begin
        exp_hit = 1'b1;
        q_hit.push_back(mem(a));
        m_hits++;
      end else begin
        m_miss++;
        m_fetching = 1'b1;
        m_faddr = a;
      end
    end
    if (iv) for (int i = 0; i < int'(SETS); i++) m_valid[i] = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("ihit_flag", 32'(bus.dp_ihit), 32'(exp_hit));
      if (bus.dp_ihit) begin
        if (q_hit.size() == 0) chk("unexpected_hit", 32'(1), 32'(0));
        else chk("hit_data", bus.dp_imemload, q_hit.pop_front());
      end else begin
        chk("load_zero", bus.dp_imemload, 32'(0));
      end
      chk("iren_flag", 32'(bus.iREN), 32'(exp_fetch));
      if (bus.iREN) begin
        if (q_fetch.size() == 0) chk("unexpected_fetch", 32'(1), 32'(0));
        else chk("fetch_addr", bus.iaddr, q_fetch.pop_front());
      end else begin
        chk("iaddr_idle", bus.iaddr, 32'(0));
      end
      chk("hit_count", 32'(hit_count), exp_hc);
      chk("miss_count", 32'(miss_count), exp_mc);
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [25:0] t;
    case ($urandom_range(0, 2))
      0:       t = 26'h0;
      1:       t = 26'h1;
      default: t = 26'h3FFFFFF;
    endcase
    return {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  logic [31:0] inv_addrs [4];
  logic [31:0] cur;

  initial begin
    mon_en = 1'b0;
    model_reset();
    nRST = 1'b0;
    inv = 1'b0;
    bus.dp_imemREN = 1'b0;
    bus.dp_imemaddr = '0;
    bus.iwait = 1'b0;
    #12;
    chk("rst_ihit", 32'(bus.dp_ihit), 32'(0));
    chk("rst_load", bus.dp_imemload, 32'(0));
    chk("rst_iren", 32'(bus.iREN), 32'(0));
    chk("rst_iaddr", bus.iaddr, 32'(0));
    chk("rst_hits", 32'(hit_count), 32'(0));
    chk("rst_misses", 32'(miss_count), 32'(0));
    @(negedge CLK);
    nRST = 1'b1;
    mon_en = 1'b1;

    // First fetch: two stall cycles, then the word from memory.
    step(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("t1_miss", 32'(bus.dp_ihit), 32'(0));
    step(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("t1_iren", 32'(bus.iREN), 32'(1));
    chk("t1_iaddr", bus.iaddr, 32'h0);
    step(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("t1_hit", 32'(bus.dp_ihit), 32'(1));
    chk("t1_data", bus.dp_imemload, 32'h3C010001);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("t1_misses", 32'(miss_count), 32'(1));

    // Conflict on index 1: 0x04, 0x44, then 0x04 again all miss.
    for (int r = 0; r < 3; r++) begin
      cur = (r == 1) ? 32'h44 : 32'h04;
      for (int c = 0; c < 3; c++) step(1'b1, cur, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("t2_misses", 32'(miss_count), 32'(4));
    chk("t2_hits", 32'(hit_count), 32'(4));

    // Five wait states on a miss to 0x10.
    step(1'b1, 32'h10, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 32'h10, 1'b0, (c < 5) ? 1'b1 : 1'b0);
      @(negedge CLK); chk("t3_iren", 32'(bus.iREN), 32'(1));
      chk("t3_iaddr", bus.iaddr, 32'h10);
    end
    step(1'b1, 32'h10, 1'b0, 1'b0);
    @(negedge CLK); chk("t3_hit", 32'(bus.dp_ihit), 32'(1));

    // Address change mid-fill: 0x20 still fills, 0x30 then misses.
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 1'b0);
    @(negedge CLK); chk("t4_miss30", 32'(bus.dp_ihit), 32'(0));
    step(1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    @(negedge CLK); chk("t4_hit20", 32'(bus.dp_ihit), 32'(1));
    chk("t4_data20", bus.dp_imemload, mem(32'h20));

    // Invalidate: every previously filled frame misses.
    inv_addrs[0] = 32'h00; inv_addrs[1] = 32'h04;
    inv_addrs[2] = 32'h10; inv_addrs[3] = 32'h20;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, inv_addrs[k], 1'b0, 1'b0);
      @(negedge CLK); chk("t5_inv_miss", 32'(bus.dp_ihit), 32'(0));
      step(1'b1, inv_addrs[k], 1'b0, 1'b0);
      step(1'b1, inv_addrs[k], 1'b0, 1'b0);
    end
    // Invalidate on the fill edge leaves the frame invalid.
    step(1'b1, 32'h80, 1'b0, 1'b0);
    step(1'b1, 32'h80, 1'b1, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    @(negedge CLK); chk("t5_edge_miss", 32'(bus.dp_ihit), 32'(0));
    step(1'b1, 32'h80, 1'b0, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    // Invalidate earlier in the fill does not cancel it.
    step(1'b1, 32'h84, 1'b0, 1'b0);
    step(1'b1, 32'h84, 1'b1, 1'b1);
    step(1'b1, 32'h84, 1'b0, 1'b0);
    step(1'b1, 32'h84, 1'b0, 1'b0);
    @(negedge CLK); chk("t5_early_hit", 32'(bus.dp_ihit), 32'(1));

    // Randomized traffic with stalls, wait states and invalidates.
    cur = rand_addr();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) < 3) cur = rand_addr();
      step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, cur,
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
    end

    // Hold one address long enough to saturate the hit counter.
    for (int n = 0; n < 300; n++) step(1'b1, 32'h84, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("sat_hits", 32'(hit_count), 32'(CMAX));

    // Reset in the middle of a fill.
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    #2;
    mon_en = 1'b0;
    nRST = 1'b0;
    bus.dp_imemREN = 1'b0;
    #1;
    chk("rst_fetch_iren", 32'(bus.iREN), 32'(0));
    chk("rst_fetch_iaddr", bus.iaddr, 32'(0));
    chk("rst_fetch_hits", 32'(hit_count), 32'(0));
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 32'h40, 1'b0, 1'b0);
    @(negedge CLK); chk("post_rst_miss", 32'(bus.dp_ihit), 32'(0));
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("post_rst_misses", 32'(miss_count), 32'(1));
    chk("post_rst_hits", 32'(hit_count), 32'(1));

    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("hit_queue_empty", 32'(q_hit.size()), 32'(0));
    chk("fetch_queue_empty", 32'(q_fetch.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
